// File: rtl/division.sv
// division: 32-bit signed restoring divider; define DIV_EARLY_ZERO_EN to finish divide-by-zero one cycle after start
module division (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_dvd, r_dvd_mag, r_dvs_mag, r_q, r_rem;
  logic        r_neg_q, r_neg_r, r_zero;
  logic [32:0] w_shift, w_diff;
  logic [31:0] w_q_fin, w_r_fin;
  logic        w_accept, w_early, w_complete;
  assign w_accept = r_state == IDLE && start && !busy;
`ifdef DIV_EARLY_ZERO_EN
  assign w_early    = divisor == '0;
  assign w_complete = r_state == FIX || (r_state == IDLE && busy);
`else
  assign w_early    = 1'b0;
  assign w_complete = r_state == FIX;
`endif
  assign w_shift = {r_rem, r_dvd_mag[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs_mag};
  assign w_q_fin = r_zero ? '1 : r_neg_q ? -r_q : r_q;
  assign w_r_fin = r_zero ? r_dvd : r_neg_r ? -r_rem : r_rem;
  // next state: 32 CALC steps then one FIX cycle; early divide-by-zero stays in IDLE
  always_comb begin
    w_next = r_state == IDLE ? (w_accept && !w_early ? CALC : IDLE) :
             r_state == CALC ? (r_cnt == 5'd31 ? FIX : CALC) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
  end
  // datapath: operand capture, one restoring step per CALC cycle, sign fix-up at completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0; r_dvd <= '0; r_dvd_mag <= '0; r_dvs_mag <= '0; r_q <= '0; r_rem <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_zero <= 1'b0;
      quotient <= '0; remainder <= '0; busy <= 1'b0; done <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= w_complete;
      if (w_complete) begin
        quotient  <= w_q_fin;
        remainder <= w_r_fin;
        div_zero  <= r_zero;
        busy      <= 1'b0;
      end
      if (w_accept) begin
        r_dvd     <= dividend;
        r_dvd_mag <= dividend[31] ? -dividend : dividend;
        r_dvs_mag <= divisor[31] ? -divisor : divisor;
        r_neg_q   <= dividend[31] ^ divisor[31];
        r_neg_r   <= dividend[31];
        r_zero    <= divisor == '0;
        r_cnt     <= '0;
        r_q       <= '0;
        r_rem     <= '0;
        busy      <= 1'b1;
      end
      if (r_state == CALC) begin
        r_rem     <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
        r_q       <= {r_q[30:0], ~w_diff[32]};
        r_dvd_mag <= r_dvd_mag << 1;
        r_cnt     <= r_cnt + 5'd1;
      end
    end
  end
endmodule
